// File: rtl/somador_datapath.sv
// somador_datapath: datapath half of the memory-based adder (Somador).
//
// Holds the operand/result memory (2^ADDR_W words), the read-data register,
// the accumulator and the result register. It is steered by the control bus
// of the adder FSM. A host port preloads operands and reads back results
// while the FSM reports ready.
//
// Optional build macro: PROTOCOL_CHECK_EN. When it is defined, a sticky
// protocol-violation flag watches the control bus. When it is undefined,
// proto_err is tied to 0 and no check logic is built.
//
// Ports:
//   clk         in   system clock, all state on posedge
//   reset       in   asynchronous active-low reset
//   address     in   FSM memory address
//   rden        in   FSM read enable (mem_q <= mem[address])
//   wren        in   FSM write enable (mem[address] <= res), ignored while ready
//   load        in   accumulate mem_q into acc
//   transf      in   copy acc into res
//   clear       in   zero acc and ovf (and proto_err)
//   ready       in   FSM idle/done; enables the host port
//   host_wr     in   host write strobe
//   host_addr   in   host address
//   host_wdata  in   host write data
//   host_rdata  out  registered host read data
//   sum_out     out  current res register
//   ovf         out  sticky accumulator carry-out
//   done        out  one-cycle pulse, the cycle after ready rises
//   proto_err   out  sticky protocol-violation flag
module somador_datapath #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              rden,
    input  logic              wren,
    input  logic              load,
    input  logic              transf,
    input  logic              clear,
    input  logic              ready,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic [DATA_W-1:0] sum_out,
    output logic              ovf,
    output logic              done,
    output logic              proto_err
);

    localparam int unsigned Depth = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    logic [DATA_W-1:0] mem_q, mem_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              ovf_q, ovf_d;
    logic              ready_q;
    logic              done_q, done_d;

    logic [DATA_W:0]   sum_full;
    logic              fsm_we;
    logic              host_we;

    // Extra top bit captures the carry-out of the accumulation.
    assign sum_full = {1'b0, acc_q} + {1'b0, mem_q};

    // The FSM owns the memory while busy and the host owns it while ready,
    // so the two write ports never collide.
    assign fsm_we  = wren & ~ready;
    assign host_we = host_wr & ready;

    always_comb begin
        mem_d        = mem_q;
        acc_d        = acc_q;
        res_d        = res_q;
        host_rdata_d = host_rdata_q;
        ovf_d        = ovf_q;
        done_d       = ready & ~ready_q;

        if (rden) begin
            mem_d = mem[address];
        end

        if (clear) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (load) begin
            acc_d = sum_full[DATA_W-1:0];
            ovf_d = ovf_q | sum_full[DATA_W];
        end

        // Load wins over transfer; res samples the pre-update acc.
        if (transf && !load) begin
            res_d = acc_q;
        end

        if (ready) begin
            host_rdata_d = mem[host_addr];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q        <= '0;
            acc_q        <= '0;
            res_q        <= '0;
            host_rdata_q <= '0;
            ovf_q        <= 1'b0;
            ready_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            acc_q        <= acc_d;
            res_q        <= res_d;
            host_rdata_q <= host_rdata_d;
            ovf_q        <= ovf_d;
            ready_q      <= ready;
            done_q       <= done_d;
        end
    end

    // Memory is deliberately not reset; reads above see the old word
    // (read-before-write) because these updates are non-blocking.
    always_ff @(posedge clk) begin
        if (fsm_we) begin
            mem[address] <= res_q;
        end
        if (host_we) begin
            mem[host_addr] <= host_wdata;
        end
    end

    assign host_rdata = host_rdata_q;
    assign sum_out    = res_q;
    assign ovf        = ovf_q;
    assign done       = done_q;

`ifdef PROTOCOL_CHECK_EN
    logic              rden_q;
    logic              wren_q;
    logic              load_q;
    logic [ADDR_W-1:0] addr_q;
    logic              proto_err_q, proto_err_d;
    logic              proto_hit;

    always_comb begin
        proto_hit = 1'b0;
        if (load && transf) begin
            proto_hit = 1'b1;
        end
        if (transf && (wren != wren_q)) begin
            proto_hit = 1'b1;
        end
        // Address must be stable across a multi-cycle read burst.
        if (rden && rden_q && (address != addr_q)) begin
            proto_hit = 1'b1;
        end
        // load rising with rden rising would accumulate a stale mem_q.
        if (load && !load_q && rden && !rden_q) begin
            proto_hit = 1'b1;
        end

        proto_err_d = proto_err_q;
        if (clear) begin
            proto_err_d = 1'b0;
        end else if (proto_hit) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rden_q      <= 1'b0;
            wren_q      <= 1'b0;
            load_q      <= 1'b0;
            addr_q      <= '0;
            proto_err_q <= 1'b0;
        end else begin
            rden_q      <= rden;
            wren_q      <= wren;
            load_q      <= load;
            addr_q      <= address;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err = proto_err_q;
`else
    assign proto_err = 1'b0;
`endif

endmodule

// File: doc/somador_datapath.md
Name: somador_datapath

Overview:
Datapath half of the memory-based adder (Somador). It responds to the control bus driven by the adder FSM: address, rden, wren, load, transf, clear and ready.
- Holds the 2^ADDR_W-word operand/result memory, the read-data register, the accumulator and the result register.
- Writes results back to memory.
- Provides a host port for preloading operands and reading back results while the FSM reports ready.

Parameters:
DATA_W, 8, word width of memory, accumulator and result
ADDR_W, 5, address width; DEPTH = 2^ADDR_W (32 words)

Ports:
clk  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-low reset
address  in  ADDR_W  FSM memory address
rden  in  1  FSM read enable
wren  in  1  FSM write enable (writes res to mem[address])
load  in  1  accumulate mem_q into acc
transf  in  1  copy acc into res
clear  in  1  zero acc and ovf
ready  in  1  FSM idle/done; enables host port
host_wr  in  1  host write strobe
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_rdata  out  DATA_W  registered host read data
sum_out  out  DATA_W  current res register
ovf  out  1  sticky accumulator carry-out
done  out  1  one-cycle pulse on ready rising edge
proto_err  out  1  sticky protocol-violation flag (see Optional Feature)

Behaviour:
- Reset (reset=0, async): mem_q, acc, res, host_rdata, ovf, done, proto_err all clear to 0; the internal ready_d register also clears to 0. Memory contents are not reset.
- Read: rden=1 at posedge -> mem_q <= mem[address]. Latency 1 cycle. mem_q holds while rden=0.
- Load: load=1 at posedge -> {c, acc} <= acc + mem_q, computed at DATA_W+1 bits. acc takes the low DATA_W bits (wraps mod 2^DATA_W). ovf <= ovf | c.
- Clear: clear=1 -> acc <= 0, ovf <= 0. Clear has priority over load in the same cycle. res is unaffected.
- Transfer: transf=1 -> res <= acc, sampling acc before any same-cycle load update. If load and transf are both 1, load is applied and transf is ignored.
- Write: wren=1 and ready=0 -> mem[address] <= res, sampling res before any same-cycle transf update. wren is ignored while ready=1.
- Same-cycle rden and wren to the same address: mem_q gets the old word (read-before-write).
- Host port, active only when ready=1:
  - host_wr=1 -> mem[host_addr] <= host_wdata.
  - Every cycle, host_rdata <= mem[host_addr], read-before-write.
  - When ready=0, host_wr is ignored and host_rdata holds its value.
- sum_out = res (registered, no added latency).
- done: ready_d <= ready; done = ready & ~ready_d, registered, so the pulse appears the cycle after ready rises.
- Reset asserted mid-operation: all registers return to their reset values immediately. Memory keeps its partially written contents.

Optional Feature:
Macro PROTOCOL_CHECK_EN.
- Defined: proto_err is set and held (sticky) when any of the following occurs:
  - load=1 and transf=1 in the same cycle;
  - wren changes value while transf=1;
  - address differs from its previous-cycle value while rden=1 in both cycles;
  - load rises in the same cycle rden rises.
- proto_err is cleared only by reset or clear=1.
- Not defined: proto_err is tied to 0 and no check logic is synthesised.

Test Plan:
1. Host preload: ready=1, host writes mem[0]=8'h10, mem[1]=8'h22; set host_addr=1 -> host_rdata=8'h22 one cycle later; no FSM write occurs.
2. Accumulate: ready=0, clear, then rden addr0, load, rden addr1, load, transf, wren addr2 -> sum_out=8'h32, ovf=0; host read of addr2 after ready=1 returns 8'h32.
3. Overflow: mem[0]=8'hF0, mem[1]=8'h20, accumulate both -> acc=8'h10, ovf=1; next clear -> acc=0, ovf=0.
4. Priority: clear and load together -> acc=0. load and transf together -> res unchanged, acc updated, proto_err=1 (PROTOCOL_CHECK_EN defined) or 0 (not defined).
5. Gating: ready=1 with wren=1 at addr3 -> mem[3] unchanged. ready=0 with host_wr=1 -> no write, host_rdata holds.
6. Reset mid-sum: assert reset after first load -> acc, res, ovf, mem_q = 0 asynchronously; memory keeps mem[0]=8'h10; ready 0->1 after release -> done pulses for exactly 1 cycle.
